inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Instruction memory responder for the fetch port of `openmips`. It answers `rom_ce_o`/`rom_addr_o` with `rom_data_i`, and includes a byte-stream loader that fills the memory at run time. While the loader is active it holds the core in reset, and it releases the core when the program image is complete. It sits at SoC top level, between the boot byte source (UART/debug bridge) and the core's `rst`.

## Interface
- `DEPTH_LOG2`, default 10: log2 of memory depth in 32-bit words (1024 words).
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `ce` input, 1 bit: fetch enable; connects to core `rom_ce_o`.
- `addr` input, 32 bits: fetch byte address; connects to core `rom_addr_o`.
- `inst` output, 32 bits: fetched word; connects to core `rom_data_i`.
- `ld_start` input, 1 bit: one-cycle pulse that begins a load.
- `ld_len` input, DEPTH_LOG2+1 bits: number of words to load, sampled with `ld_start`.
- `ld_valid` input, 1 bit: byte-source valid.
- `ld_data` input, 8 bits: byte to load.
- `ld_ready` output, 1 bit: loader accepts a byte.
- `ld_done` output, 1 bit: one-cycle pulse when the load is complete.
- `busy` output, 1 bit: high while in LOAD.
- `cpu_rst_o` output, 1 bit: reset to the core.
- `err_o` output, 1 bit: sticky fetch error; only active with the configuration macro.

## Operation
- States are BOOT, LOAD and RUN. Reset enters BOOT.
- BOOT: `cpu_rst_o`=1, `ld_ready`=0. `ld_start` latches `ld_len` into `words_left`, clears the byte counter and the word-address counter, and moves to LOAD.
- BOOT with `ld_start` and `ld_len`=0: goes directly to RUN and pulses `ld_done`.
- LOAD: `ld_ready`=1, `busy`=1, `cpu_rst_o`=1. A byte is accepted on an edge where `ld_valid && ld_ready`.
  - Bytes are assembled big-endian: the first byte goes to [31:24] and the fourth byte to [7:0].
  - The 2-bit byte counter wraps 3→0.
  - On acceptance of the 4th byte, the word is written to `mem[waddr]`, `waddr` increments modulo 2^DEPTH_LOG2 (wrap overwrites), and `words_left` decrements.
  - When `words_left` reaches 0, the block moves to RUN.
  - `ld_start` is ignored while in LOAD.
- RUN: `cpu_rst_o`=0, `ld_ready`=0. `ld_start` re-enters LOAD, which reasserts `cpu_rst_o` (program reload).
- Fetch read is combinational:
  - `inst` = `mem[addr[DEPTH_LOG2+1:2]]` when `ce`=1.
  - `inst` = 0 when `ce`=0.
  - `inst` = 0 in BOOT and LOAD.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values:
  - state BOOT
  - `ld_ready`=0, `ld_done`=0, `busy`=0, `err_o`=0
  - `cpu_rst_o`=1
  - `inst`=0
  - byte counter, `waddr` and `words_left` = 0
- `cpu_rst_o` = `rst` OR (state != RUN).
- The core sees `rst` deassert in the same cycle as `ld_done`.
- Write latency: a word written on edge N is readable by fetch in cycle N+1.
- `ld_done` is registered. It is high for exactly the one cycle after the edge that accepted the last byte, and that is the first RUN cycle.
- `ld_start` arriving together with the final byte is ignored.
- Fetch path has zero-cycle latency, which matches the single-cycle IF stage of the core.
- `rst` during LOAD:
  - next cycle is BOOT
  - a partially assembled word is discarded
  - words already written are retained
  - `ld_done` is not pulsed
- `ld_valid` bubbles do not advance any counter.

## Configuration
- Macro: `INST_ROM_ADDR_CHK_EN`.
- Defined:
  - A RUN-state fetch with `ce`=1 and either `addr[1:0]`!=0 or `addr` >= 4·2^DEPTH_LOG2 returns `inst`=0 (NOP).
  - The same fetch sets `err_o`=1 on the next edge.
  - `err_o` stays set until `rst` or the next `ld_start`.
- Undefined:
  - `addr[1:0]` and the upper address bits are ignored; the address wraps modulo depth.
  - `err_o` is tied to 0.

## Test plan
- Load of two words:
  - Stimulus: after reset, `ld_start` with `ld_len`=2, then bytes 34 02 00 01 34 03 00 02 back-to-back.
  - Response: `ld_done`=1 and `cpu_rst_o`=0 one cycle after the 8th byte.
  - Response: `ce`=1, `addr`=0 gives 0x34020001; `addr`=4 gives 0x34030002.
- Valid bubbles: same load with `ld_valid` toggling every other cycle gives identical memory contents, and `ld_done` comes one cycle after the last accepted byte.
- Fetch disable: `ce`=0 in RUN gives `inst`=0x00000000 for every `addr`.
- Zero-length load: `ld_start` with `ld_len`=0 from BOOT gives RUN and `ld_done`=1 on the next cycle, and no memory write.
- Reset mid-load:
  - Stimulus: `rst` after 5 bytes of a 2-word load.
  - Response: state BOOT, `ld_ready`=0, `cpu_rst_o`=1.
  - Response: a later 0-word load and a fetch at `addr`=0 still returns word 0.
- Address check: with `INST_ROM_ADDR_CHK_EN`, a fetch at `addr`=0x2 gives `inst`=0 and `err_o`=1 on the next cycle. Without the macro, the same fetch returns word 0 and `err_o`=0.

Source files
------------

// File: rtl/inst_rom_loader.sv
// inst_rom_loader
// Instruction memory for the openmips fetch port, with a byte-stream loader
// that fills the memory at run time and holds the core in reset while
// loading.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   ce, addr, inst    fetch port (core rom_ce_o / rom_addr_o / rom_data_i)
//   ld_start, ld_len  start a load of ld_len 32-bit words
//   ld_valid, ld_data byte stream, big-endian within each word
//   ld_ready          loader accepts a byte (LOAD state)
//   ld_done           one-cycle pulse in the first RUN cycle after a load
//   busy              high while loading
//   cpu_rst_o         reset to the core
//   err_o             sticky bad-fetch flag
//
// Optional feature macro: INST_ROM_ADDR_CHK_EN
//   defined   : misaligned or out-of-range RUN fetches return 0 and set err_o
//   undefined : address wraps modulo depth, err_o tied to 0
//
// state | meaning
// BOOT  | after reset, core held in reset, waiting for ld_start
// LOAD  | accepting bytes, core held in reset
// RUN   | core released, memory serves fetches
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  ld_start,
  input  logic [DEPTH_LOG2:0]   ld_len,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  busy,
  output logic                  cpu_rst_o,
  output logic                  err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {BOOT, LOAD, RUN} state_t;

  state_t                state, state_nxt;
  logic [1:0]            byte_cnt;
  logic [23:0]           byte_buf;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DEPTH_LOG2:0]   words_left;
  logic [31:0]           mem [DEPTH];

  logic                  start_load;
  logic                  start_empty;
  logic                  accept;
  logic                  word_done;
  logic                  last_word;
  logic                  fetch_on;
  logic [DEPTH_LOG2-1:0] raddr;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ld_ready    = 1'b0;
    busy        = 1'b0;
    start_load  = 1'b0;
    start_empty = 1'b0;
    accept      = 1'b0;
    word_done   = 1'b0;
    last_word   = 1'b0;
    case (state)
      BOOT, RUN: begin
        if (ld_start) begin
          // a zero-length load completes immediately
          if (ld_len == '0) begin
            start_empty = 1'b1;
            state_nxt   = RUN;
          end else begin
            start_load = 1'b1;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: begin
        ld_ready  = 1'b1;
        busy      = 1'b1;
        accept    = ld_valid;
        word_done = accept && (byte_cnt == 2'd3);
        last_word = word_done && (words_left == (DEPTH_LOG2+1)'(1));
        if (last_word) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      byte_buf   <= 24'd0;
      waddr      <= '0;
      words_left <= '0;
      ld_done    <= 1'b0;
    end else begin
      ld_done <= start_empty | last_word;
      if (start_load || start_empty) begin
        words_left <= ld_len;
        byte_cnt   <= 2'd0;
        waddr      <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    byte_buf[23:16] <= ld_data;
          2'd1:    byte_buf[15:8]  <= ld_data;
          2'd2:    byte_buf[7:0]   <= ld_data;
          default: ;
        endcase
        if (word_done) begin
          waddr      <= waddr + 1'b1;
          words_left <= words_left - 1'b1;
        end
      end
    end
  end

  // Memory has no reset so a reset mid-load keeps already written words;
  // a final byte arriving with rst is dropped along with the partial word.
  always_ff @(posedge clk) begin
    if (word_done && !rst) mem[waddr] <= {byte_buf, ld_data};
  end

  assign cpu_rst_o = rst | (state != RUN);
  assign fetch_on  = (state == RUN) && ce;
  assign raddr     = addr[DEPTH_LOG2+1:2];

`ifdef INST_ROM_ADDR_CHK_EN
  logic addr_bad;

  assign addr_bad = (addr[1:0] != 2'd0) || ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_comb begin
    inst = 32'd0;
    if (fetch_on && !addr_bad) inst = mem[raddr];
  end

  // a new load request clears the flag; a load in progress cannot set it
  always_ff @(posedge clk) begin
    if (rst)                               err_o <= 1'b0;
    else if (ld_start && (state != LOAD))  err_o <= 1'b0;
    else if (fetch_on && addr_bad)         err_o <= 1'b1;
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = &{1'b0, addr[31:DEPTH_LOG2+2], addr[1:0]};

  always_comb begin
    inst = 32'd0;
    if (fetch_on) inst = mem[raddr];
  end

  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef INST_ROM_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] bytes8_t [8];

  logic                clk;
  logic                rst;
  logic                ce;
  logic [31:0]         addr;
  logic [31:0]         inst;
  logic                ld_start;
  logic [DEPTH_LOG2:0] ld_len;
  logic                ld_valid;
  logic [7:0]          ld_data;
  logic                ld_ready;
  logic                ld_done;
  logic                busy;
  logic                cpu_rst_o;
  logic                err_o;

  int checks   = 0;
  int failures = 0;

  inst_rom_loader #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .busy(busy), .cpu_rst_o(cpu_rst_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = core held waiting, 1 = loading, 2 = running
  int          m_mode  = 0;
  bit          live    = 0;
  bit          m_done  = 0;
  bit          m_err   = 0;
  int          m_left  = 0;
  int          m_waddr = 0;
  logic [7:0]  m_q [$];
  logic [31:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'd0) || (a >= 32'(4 * DEPTH));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_q.delete(); m_done = 0; m_err = 0; live = 1;
    end else begin
      m_done = 0;
      if (m_mode == 1) begin
        if (ld_valid) begin
          m_q.push_back(ld_data);
          if (m_q.size() == 4) begin
            m_mem[m_waddr]   = {m_q[0], m_q[1], m_q[2], m_q[3]};
            m_valid[m_waddr] = 1;
            m_waddr = (m_waddr + 1) % DEPTH;
            m_left--;
            m_q.delete();
            if (m_left == 0) begin m_mode = 2; m_done = 1; end
          end
        end
      end else begin
        if (CHK && m_mode == 2 && ce && bad_addr(addr)) m_err = 1;
        if (ld_start) begin
          m_err = 0; m_q.delete(); m_waddr = 0; m_left = int'(ld_len);
          if (ld_len == 0) begin m_mode = 2; m_done = 1; end
          else m_mode = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      logic [31:0] e_inst;
      bit          e_known;
      int          idx;
      idx     = int'(addr[DEPTH_LOG2+1:2]);
      e_inst  = 32'd0;
      e_known = 1;
      if (m_mode == 2 && ce && !(CHK && bad_addr(addr))) begin
        e_known = m_valid[idx];
        e_inst  = m_mem[idx];
      end
      if (e_known) check("cyc_inst", inst, e_inst);
      check("cyc_cpu_rst", 32'(cpu_rst_o), 32'(rst || m_mode != 2));
      check("cyc_ld_ready", 32'(ld_ready), 32'(m_mode == 1));
      check("cyc_busy", 32'(busy), 32'(m_mode == 1));
      check("cyc_ld_done", 32'(ld_done), 32'(m_done));
      check("cyc_err", 32'(err_o), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int len, input bytes8_t b, input int n, input bit bubbles, input bit poke);
    ld_start = 1'b1;
    ld_len   = (DEPTH_LOG2+1)'(len);
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        ld_valid = 1'b0;
        ld_data  = 8'hFF;
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = b[i];
      if (poke && (i == 2 || i == n - 1)) begin
        ld_start = 1'b1;
        ld_len   = '0;
      end
      tick();
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
  endtask

  task automatic fetch_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    ce   = 1'b1;
    addr = a;
    @(negedge clk);
    check(name, inst, exp);
    tick();
  endtask

  bytes8_t prog_a = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
  bytes8_t prog_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  bytes8_t prog_c = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00, 8'h00, 8'h00};
  logic [31:0] off_addrs [5] = '{32'h0, 32'h4, 32'h8, 32'h2, 32'hFFFF_FFFC};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b1; addr = 32'd0; ld_start = 1'b0; ld_len = '0;
    ld_valid = 1'b0; ld_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("boot_cpu_rst", 32'(cpu_rst_o), 32'd1);
    tick();

    // two-word load, back-to-back bytes
    load(2, prog_a, 8, 1'b0, 1'b0);
    @(negedge clk);
    check("load_a_done", 32'(ld_done), 32'd1);
    check("load_a_cpu_rst", 32'(cpu_rst_o), 32'd0);
    tick();
    @(negedge clk);
    check("load_a_done_1cyc", 32'(ld_done), 32'd0);
    tick();
    fetch_chk(32'h0, 32'h3402_0001, "fetch_a0");
    fetch_chk(32'h4, 32'h3403_0002, "fetch_a1");

    // fetch disabled
    for (int i = 0; i < 5; i++) begin
      ce   = 1'b0;
      addr = off_addrs[i];
      @(negedge clk);
      check("ce_off_inst", inst, 32'd0);
      tick();
    end

    // misaligned and out-of-range fetches
    fetch_chk(32'h2, CHK ? 32'd0 : 32'h3402_0001, "fetch_misaligned");
    addr = 32'h0;
    @(negedge clk);
    check("err_after_misaligned", 32'(err_o), CHK ? 32'd1 : 32'd0);
    tick();
    fetch_chk(32'h1000, CHK ? 32'd0 : 32'h3402_0001, "fetch_out_of_range");

    // reload from RUN with ld_start pokes during LOAD and with final byte
    load(2, prog_b, 8, 1'b0, 1'b1);
    @(negedge clk);
    check("load_b_done", 32'(ld_done), 32'd1);
    check("load_b_err_cleared", 32'(err_o), 32'd0);
    tick();
    @(negedge clk);
    check("load_b_busy_after", 32'(busy), 32'd0);
    tick();
    fetch_chk(32'h0, 32'h1122_3344, "fetch_b0");
    fetch_chk(32'h4, 32'h5566_7788, "fetch_b1");

    // reload with ld_valid bubbles
    load(2, prog_a, 8, 1'b1, 1'b0);
    @(negedge clk);
    check("bubble_done", 32'(ld_done), 32'd1);
    tick();
    fetch_chk(32'h0, 32'h3402_0001, "bubble_a0");
    fetch_chk(32'h4, 32'h3403_0002, "bubble_a1");

    // zero-length load from BOOT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ld_start = 1'b1;
    ld_len   = '0;
    tick();
    ld_start = 1'b0;
    @(negedge clk);
    check("zero_len_done", 32'(ld_done), 32'd1);
    check("zero_len_cpu_rst", 32'(cpu_rst_o), 32'd0);
    tick();
    fetch_chk(32'h0, 32'h3402_0001, "zero_len_no_write");

    // reset after five bytes of a two-word load
    load(2, prog_c, 5, 1'b0, 1'b0);
    @(negedge clk);
    check("midload_cpu_rst", 32'(cpu_rst_o), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    ld_start = 1'b1;
    ld_len   = '0;
    tick();
    ld_start = 1'b0;
    fetch_chk(32'h0, 32'hAABB_CCDD, "midrst_word0_kept");
    fetch_chk(32'h4, 32'h3403_0002, "midrst_word1_untouched");

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
